img_rom_stream_ctrl: RTL and testbench

- Sequences reads from the single-port image ROM (512x512x24-bit, 1-cycle read latency) and emits pixels as an AXI-Stream-style master with full tready backpressure.
- Adds start/stop/busy/done control, plus start-of-frame and end-of-line markers.
- Sits between the image ROM and downstream pixel-processing blocks.
- Supports single-shot and continuous frame modes.

---
 rtl/img_stream_pkg.sv | 27 ++
 rtl/img_skid_buf.sv | 72 +++++++
 rtl/img_rom_stream_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_img_rom_stream_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_stream_pkg.sv
// Shared types and defaults for the image ROM streaming controller.
//   - state_t    : controller FSM states (IDLE, RUN, DRAIN)
//   - sideband_t : per-pixel stream markers that travel with the data
//   - cnt_w()    : counter width for a 0..n-1 range, never below 1 bit
package img_stream_pkg;

   localparam int DATA_W_DEF = 24;
   localparam int IMG_W_DEF  = 512;
   localparam int IMG_H_DEF  = 512;
   localparam int ADDR_W_DEF = 18;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic tuser;
      logic tlast;
   } sideband_t;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/img_skid_buf.sv
// Two-entry valid/ready buffer carrying {data, tuser, tlast}.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_data/in_user/in_last   write side (no ready: the writer
//                              only pushes when it holds a credit)
//   out_valid/out_ready/out_data/out_user/out_last   stream read side
//   count                      current occupancy (0..2) for credit logic
// The read side is taken straight from the storage registers, so output
// valid and payload never depend combinationally on out_ready.
module img_skid_buf
   import img_stream_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_user,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_user,
   output logic              out_last,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] data_q [2];
   sideband_t         sb_q   [2];
   logic              rd_ptr_q;
   logic              wr_ptr_q;
   logic [1:0]        count_q;
   logic              push;
   logic              pop;

   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && (count_q != 2'd2);
   assign pop       = out_valid && out_ready;

   assign out_data  = data_q[rd_ptr_q];
   assign out_user  = sb_q[rd_ptr_q].tuser;
   assign out_last  = sb_q[rd_ptr_q].tlast;
   assign count     = count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            data_q[i] <= '0;
            sb_q[i]   <= '0;
         end
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            data_q[wr_ptr_q] <= in_data;
            sb_q[wr_ptr_q]   <= '{tuser: in_user, tlast: in_last};
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/img_rom_stream_ctrl.sv
// Reads an image ROM (1-cycle read latency) in raster order and streams
// the pixels out as a stream master with full backpressure.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, cfg_continuous start pulse (ignored while busy); continuous
//                         mode is latched on the accepted start
//   stop                  ends the run at the next frame boundary
//   busy, done            busy in RUN/DRAIN; done pulses once when the
//                         last beat of the last frame has been accepted
//   frame_cnt             frames fully delivered since reset (wraps)
//   rom_en, rom_addr, rom_dout   ROM read port
//   m_tdata/m_tvalid/m_tready/m_tuser/m_tlast   pixel stream
// Build option IMG_TPG_EN adds cfg_tpg (latched on start): the ROM is
// left idle and the pixel becomes {x[7:0], y[7:0], frame_cnt[7:0]}.
//
// Stream handshake: a beat transfers on a cycle where m_tvalid and
// m_tready are both high. Once m_tvalid rises, m_tvalid, m_tdata, m_tuser
// and m_tlast stay unchanged until that transfer; m_tvalid is a register
// output and never looks at m_tready in the same cycle.
module img_rom_stream_ctrl
   import img_stream_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IMG_W  = IMG_W_DEF,
   parameter int IMG_H  = IMG_H_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
`ifdef IMG_TPG_EN
   input  logic              cfg_tpg,
`endif
   input  logic              cfg_continuous,
   input  logic              stop,
   output logic              busy,
   output logic              done,
   output logic [15:0]       frame_cnt,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_dout,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tuser,
   output logic              m_tlast
);

   localparam int X_W = cnt_w(IMG_W);
   localparam int Y_W = cnt_w(IMG_H);
   localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

   state_t            state_q, state_d;
   logic [X_W-1:0]    x_q;
   logic [Y_W-1:0]    y_q;
   logic [Y_W-1:0]    out_y_q;     // line index of the beat at the output
   logic [ADDR_W-1:0] addr_q;
   logic              cont_q;
   logic              stop_q;
   logic              infl_q;      // a read issued last cycle lands now
   sideband_t         infl_sb_q;
   logic [15:0]       frame_cnt_q;

   logic              issue;
   logic              pop;
   logic [1:0]        buf_count;
   logic [2:0]        pending;
   logic              last_x, last_y, last_pix;
   logic              frame_continue;
   sideband_t         issue_sb;
   logic [DATA_W-1:0] push_data;

   assign last_x   = (x_q == X_LAST);
   assign last_y   = (y_q == Y_LAST);
   assign last_pix = last_x && last_y;
   assign issue_sb = '{tuser: (x_q == '0) && (y_q == '0), tlast: last_x};

   // A stop arriving in the same cycle as the final issue still counts.
   assign frame_continue = cont_q && !stop_q && !stop;

   // Entries left after this cycle's pop plus the read still in flight
   // must leave room for one more, so the buffer can never overflow.
   assign pop     = m_tvalid && m_tready;
   assign pending = 3'(buf_count) + 3'(infl_q) - 3'(pop);
   assign issue   = (state_q == RUN) && (pending < 3'd2);

   assign busy      = (state_q != IDLE);
   assign rom_addr  = addr_q;
   assign frame_cnt = frame_cnt_q;

`ifdef IMG_TPG_EN
   logic              tpg_q;
   logic [DATA_W-1:0] tpg_data_q;
   logic [23:0]       tpg_raw;

   assign tpg_raw   = {8'(x_q), 8'(y_q), frame_cnt_q[7:0]};
   assign rom_en    = issue && !tpg_q;
   assign push_data = tpg_q ? tpg_data_q : rom_dout;

   // Pattern word is registered at issue so it lines up with where ROM
   // data would have arrived.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tpg_q      <= 1'b0;
         tpg_data_q <= '0;
      end else begin
         if (state_q == IDLE && start) begin
            tpg_q <= cfg_tpg;
         end
         if (issue) begin
            tpg_data_q <= DATA_W'(tpg_raw);
         end
      end
   end
`else
   assign rom_en    = issue;
   assign push_data = rom_dout;
`endif

   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            if (issue && last_pix && !frame_continue) state_d = DRAIN;
         end
         DRAIN: begin
            if (buf_count == 2'd0 && !infl_q) begin
               state_d = IDLE;
               done    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         out_y_q     <= '0;
         addr_q      <= '0;
         cont_q      <= 1'b0;
         stop_q      <= 1'b0;
         infl_q      <= 1'b0;
         infl_sb_q   <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         infl_q    <= issue;
         infl_sb_q <= issue_sb;

         if (state_q == IDLE && start) begin
            cont_q <= cfg_continuous;
            stop_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
         end else if (state_q == RUN) begin
            if (stop) stop_q <= 1'b1;
            if (issue) begin
               // Always wrap after the last pixel so a continuous run
               // starts the next frame with no bubble.
               addr_q <= last_pix ? '0 : addr_q + ADDR_W'(1);
               if (last_x) begin
                  x_q <= '0;
                  y_q <= last_y ? '0 : y_q + Y_W'(1);
               end else begin
                  x_q <= x_q + X_W'(1);
               end
            end
         end

         // Frame completion is tracked on the output side by counting
         // accepted end-of-line beats.
         if (pop && m_tlast) begin
            if (out_y_q == Y_LAST) begin
               out_y_q     <= '0;
               frame_cnt_q <= frame_cnt_q + 16'd1;
            end else begin
               out_y_q <= out_y_q + Y_W'(1);
            end
         end
      end
   end

   img_skid_buf #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (infl_q),
      .in_data   (push_data),
      .in_user   (infl_sb_q.tuser),
      .in_last   (infl_sb_q.tlast),
      .out_valid (m_tvalid),
      .out_ready (m_tready),
      .out_data  (m_tdata),
      .out_user  (m_tuser),
      .out_last  (m_tlast),
      .count     (buf_count)
   );

endmodule

// File: tb/tb_img_rom_stream_ctrl.sv
// Testbench for img_rom_stream_ctrl with a 4x3 image and a modelled ROM.
module tb_img_rom_stream_ctrl;

   localparam int DATA_W = 24;
   localparam int IMG_W  = 4;
   localparam int IMG_H  = 3;
   localparam int ADDR_W = 4;
   localparam int NPIX   = IMG_W * IMG_H;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              cfg_continuous;
   logic              cfg_tpg;
   logic              stop;
   logic              busy;
   logic              done;
   logic [15:0]       frame_cnt;
   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_dout = '0;
   logic [DATA_W-1:0] m_tdata;
   logic              m_tvalid;
   logic              m_tready;
   logic              m_tuser;
   logic              m_tlast;

   int checks    = 0;
   int failures  = 0;
   int beats_total  = 0;
   int issues_total = 0;
   int done_total   = 0;
   int outst        = 0;
   int rdy_mode     = 0;

   logic [DATA_W+1:0] exp_q[$];

   typedef struct {
      string name;
      bit    cont;
      int    rdy;
      int    stop_beat;
      bit    stop_idle;
      bit    extra_start;
      int    exp_beats;
      int    exp_frames;
      int    exp_lat;
   } scen_t;

   scen_t tbl[5];

   img_rom_stream_ctrl #(
      .DATA_W (DATA_W),
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
`ifdef IMG_TPG_EN
      .cfg_tpg        (cfg_tpg),
`endif
      .cfg_continuous (cfg_continuous),
      .stop           (stop),
      .busy           (busy),
      .done           (done),
      .frame_cnt      (frame_cnt),
      .rom_en         (rom_en),
      .rom_addr       (rom_addr),
      .rom_dout       (rom_dout),
      .m_tdata        (m_tdata),
      .m_tvalid       (m_tvalid),
      .m_tready       (m_tready),
      .m_tuser        (m_tuser),
      .m_tlast        (m_tlast)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- ROM model ----------------
   function automatic logic [DATA_W-1:0] rom_val(input int a);
      return {8'hA5, 8'(a), 8'h3C ^ 8'(a)};
   endfunction

   always @(posedge clk) begin
      if (rom_en) rom_dout <= rom_val(int'(rom_addr));
   end

   // ---------------- ready driver ----------------
   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
   end

   // ---------------- check helper ----------------
   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic              stall_prev;
      logic [DATA_W+1:0] prev_word;
      logic [DATA_W+1:0] word;
      logic [DATA_W+1:0] e;
      stall_prev = 1'b0;
      prev_word  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_prev = 1'b0;
            outst      = 0;
         end else begin
            word = {m_tuser, m_tlast, m_tdata};
            if (stall_prev) begin
               checks++;
               if (!m_tvalid || word != prev_word) begin
                  failures++;
                  $display("FAIL stall_hold: got valid=%b word=%h required valid=1 word=%h",
                           m_tvalid, word, prev_word);
               end
            end
            if (rom_en) begin
               issues_total++;
               outst++;
            end
            if (m_tvalid && m_tready) begin
               beats_total++;
               outst--;
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL beat_extra: got word=%h required no beat", word);
               end else begin
                  e = exp_q.pop_front();
                  if (word != e) begin
                     failures++;
                     $display("FAIL beat_data: got {user,last,data}=%h required %h", word, e);
                  end
               end
            end
            if (rom_en) begin
               checks++;
               if (outst > 2) begin
                  failures++;
                  $display("FAIL issue_ahead: got %0d outstanding required <= 2", outst);
               end
            end
            if (done) done_total++;
            stall_prev = m_tvalid && !m_tready;
            prev_word  = word;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_frame(input logic tpg, input logic [7:0] fc);
      for (int a = 0; a < NPIX; a++) begin
         int x;
         int y;
         logic [DATA_W-1:0] d;
         x = a % IMG_W;
         y = a / IMG_W;
         d = tpg ? {8'(x), 8'(y), fc} : rom_val(a);
         exp_q.push_back({(x == 0 && y == 0), (x == IMG_W - 1), d});
      end
   endtask

   task automatic check_reset_outputs(input string p);
      check({p, "_busy"},      busy,      0);
      check({p, "_done"},      done,      0);
      check({p, "_frame_cnt"}, frame_cnt, 0);
      check({p, "_rom_en"},    rom_en,    0);
      check({p, "_rom_addr"},  rom_addr,  0);
      check({p, "_tvalid"},    m_tvalid,  0);
      check({p, "_tuser"},     m_tuser,   0);
      check({p, "_tlast"},     m_tlast,   0);
      check({p, "_tdata"},     m_tdata,   0);
   endtask

   task automatic run_scenario(input scen_t s);
      int          b0, d0, nb, lat, gaps;
      logic [15:0] f0;
      bit          stop_sent, fin;
      lat       = -1;
      gaps      = 0;
      stop_sent = 0;
      fin       = 0;
      rdy_mode  = s.rdy;
      for (int f = 0; f < s.exp_frames; f++) push_frame(cfg_tpg, 8'(frame_cnt + 16'(f)));
      if (s.stop_idle) begin
         @(posedge clk); #2; stop = 1'b1;
         @(posedge clk); #2; stop = 1'b0;
      end
      @(posedge clk); #2;
      b0 = beats_total;
      d0 = done_total;
      f0 = frame_cnt;
      start = 1'b1;
      cfg_continuous = s.cont;
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         @(posedge clk); #2;
         start = 1'b0;
         stop  = 1'b0;
         // Later edges of this input must not matter.
         cfg_continuous = !s.cont;
         nb = beats_total - b0;
         if (lat < 0 && m_tvalid) lat = cyc + 1;
         if (lat >= 0 && nb < s.exp_beats && !m_tvalid) gaps++;
         if (s.stop_beat >= 0 && !stop_sent && nb >= s.stop_beat) begin
            stop = 1'b1;
            stop_sent = 1;
         end
         if (s.extra_start && (nb == 3 || nb == 7)) start = 1'b1;
         if (done_total != d0) fin = 1;
      end
      start = 1'b0;
      stop  = 1'b0;
      check({s.name, "_done_seen"}, fin, 1);
      repeat (6) @(posedge clk);
      #2;
      check({s.name, "_beats"},  beats_total - b0, s.exp_beats);
      check({s.name, "_dones"},  done_total - d0, 1);
      check({s.name, "_frames"}, 16'(frame_cnt - f0), s.exp_frames);
      check({s.name, "_idle"},   busy, 0);
      check({s.name, "_leftover"}, exp_q.size(), 0);
      check({s.name, "_latency"}, lat, s.exp_lat);
      if (s.rdy == 0) check({s.name, "_gaps"}, gaps, 0);
      exp_q.delete();
   endtask

   // ---------------- main test ----------------
   initial begin
      int    b0, d0;
      scen_t s_tpg;
      tbl[0] = '{"single_rdy",  1'b0, 0, -1, 1'b0, 1'b0, 12, 1, 3};
      tbl[1] = '{"single_rand", 1'b0, 1, -1, 1'b0, 1'b0, 12, 1, 3};
      tbl[2] = '{"cont_stop",   1'b1, 0, 16, 1'b1, 1'b0, 24, 2, 3};
      tbl[3] = '{"start_busy",  1'b0, 0, -1, 1'b0, 1'b1, 12, 1, 3};
      tbl[4] = '{"cont_rand",   1'b1, 1, 14, 1'b0, 1'b0, 24, 2, 3};

      rst_n = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      cfg_continuous = 1'b0;
      cfg_tpg = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 5; i++) run_scenario(tbl[i]);

      // Reset in the middle of a frame, then replay from address 0.
      rdy_mode = 0;
      push_frame(1'b0, 8'd0);
      @(posedge clk); #2;
      b0 = beats_total;
      d0 = done_total;
      start = 1'b1;
      cfg_continuous = 1'b0;
      @(posedge clk); #2;
      start = 1'b0;
      for (int cyc = 0; cyc < 100 && (beats_total - b0) < 6; cyc++) begin
         @(negedge clk); #1;
      end
      check("rst_mid_reached", beats_total - b0, 6);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      exp_q.delete();
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      check("rst_mid_no_done", done_total - d0, 0);
      repeat (2) @(posedge clk);
      run_scenario(tbl[0]);
      check("rst_mid_frame_cnt", frame_cnt, 1);

`ifdef IMG_TPG_EN
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      cfg_tpg = 1'b1;
      b0 = issues_total;
      s_tpg = '{"tpg", 1'b0, 0, -1, 1'b0, 1'b0, 12, 1, 3};
      run_scenario(s_tpg);
      check("tpg_no_rom_en", issues_total - b0, 0);
      cfg_tpg = 1'b0;
`else
      s_tpg = tbl[0];
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish required finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
